// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master (icache/dcache) system bus arbiter; optional ARB_TIMEOUT_EN watchdog
module mem_bus_arbiter #(
    parameter int                     BUS_DATA_WIDTH = 64,
    parameter int                     BUS_TAG_WIDTH  = 13,
    parameter logic [BUS_TAG_WIDTH-1:0] INV_TAG      = 13'h800,
    parameter int                     TIMEOUT_CYCLES = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      icache_busreq,
    input  logic                      dcache_busreq,
    input  logic                      icache_busidle,
    input  logic                      dcache_busidle,
    output logic                      icache_busgrant,
    output logic                      dcache_busgrant,
    input  logic                      icache_reqcyc,
    input  logic                      dcache_reqcyc,
    input  logic                      icache_respack,
    input  logic                      dcache_respack,
    input  logic [BUS_DATA_WIDTH-1:0] icache_req,
    input  logic [BUS_DATA_WIDTH-1:0] dcache_req,
    input  logic [BUS_TAG_WIDTH-1:0]  icache_reqtag,
    input  logic [BUS_TAG_WIDTH-1:0]  dcache_reqtag,
    output logic                      icache_respcyc,
    output logic                      dcache_respcyc,
    output logic                      icache_reqack,
    output logic                      dcache_reqack,
    output logic [BUS_DATA_WIDTH-1:0] icache_resp,
    output logic [BUS_DATA_WIDTH-1:0] dcache_resp,
    output logic [BUS_TAG_WIDTH-1:0]  icache_resptag,
    output logic [BUS_TAG_WIDTH-1:0]  dcache_resptag,
    output logic                      bus_reqcyc,
    output logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_req,
    output logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    input  logic                      bus_respcyc,
    input  logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_resp,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_resptag
`ifdef ARB_TIMEOUT_EN
    ,
    output logic                      arb_timeout
`endif
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_OWN_I = 2'd1;
    localparam logic [1:0] S_OWN_D = 2'd2;
    localparam logic [1:0] S_TURN  = 2'd3;

    logic [1:0] r_state;
    logic       r_started;
    logic       r_last_owner_d;   // 1: D owned last, so I wins the next tie

    logic w_own_i;
    logic w_own_d;
    logic w_own;
    logic w_any_req;
    logic w_pick_d;
    logic w_owner_reqcyc;
    logic w_owner_busidle;
    logic w_release;
    logic w_timeout;
    logic w_is_inv;

    assign w_own_i         = (r_state == S_OWN_I);
    assign w_own_d         = (r_state == S_OWN_D);
    assign w_own           = w_own_i | w_own_d;
    assign w_any_req       = icache_busreq | dcache_busreq;
    // Round-robin: D wins only if I is absent or I was the last owner
    assign w_pick_d        = dcache_busreq & (~icache_busreq | ~r_last_owner_d);
    assign w_owner_reqcyc  = w_own_i ? icache_reqcyc  : dcache_reqcyc;
    assign w_owner_busidle = w_own_i ? icache_busidle : dcache_busidle;
    // Ownership is only given back once the owner has issued something and gone idle
    assign w_release       = w_own & r_started & w_owner_busidle;
    assign w_is_inv        = (bus_resptag == INV_TAG);

`ifdef ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] r_cnt;

    assign w_timeout = w_own & ~r_started & (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    // Watchdog: count idle ownership cycles before the owner's first request
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt       <= '0;
            arb_timeout <= 1'b0;
        end else begin
            if (w_own && !r_started && !w_timeout)
                r_cnt <= r_cnt + 1'b1;
            else
                r_cnt <= '0;
            if (w_timeout)
                arb_timeout <= 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Ownership FSM; TURN also arbitrates so the next owner is granted right after turnaround
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_started      <= 1'b0;
            r_last_owner_d <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE, S_TURN: begin
                    r_started <= 1'b0;
                    if (w_any_req)
                        r_state <= w_pick_d ? S_OWN_D : S_OWN_I;
                    else
                        r_state <= S_IDLE;
                end
                default: begin
                    if (w_release || w_timeout) begin
                        r_state        <= S_TURN;
                        r_started      <= 1'b0;
                        r_last_owner_d <= w_own_d;
                    end else if (w_owner_reqcyc) begin
                        r_started <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign icache_busgrant = w_own_i;
    assign dcache_busgrant = w_own_d;

    assign bus_reqcyc  = w_own_i ? icache_reqcyc  : (w_own_d ? dcache_reqcyc  : 1'b0);
    assign bus_respack = w_own_i ? icache_respack : (w_own_d ? dcache_respack : 1'b0);
    assign bus_req     = w_own_i ? icache_req     : (w_own_d ? dcache_req     : '0);
    assign bus_reqtag  = w_own_i ? icache_reqtag  : (w_own_d ? dcache_reqtag  : '0);

    // Snoop invalidates always go to D; other responses only to the owner
    assign icache_respcyc = bus_respcyc & w_own_i & ~w_is_inv;
    assign dcache_respcyc = bus_respcyc & (w_own_d | w_is_inv);
    assign icache_reqack  = bus_reqack & w_own_i;
    assign dcache_reqack  = bus_reqack & w_own_d;

    assign icache_resp    = bus_resp;
    assign dcache_resp    = bus_resp;
    assign icache_resptag = bus_resptag;
    assign dcache_resptag = bus_resptag;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - scoreboard testbench for mem_bus_arbiter
module tb_mem_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        icache_busreq, dcache_busreq, icache_busidle, dcache_busidle;
    logic        icache_busgrant, dcache_busgrant;
    logic        icache_reqcyc, dcache_reqcyc, icache_respack, dcache_respack;
    logic [63:0] icache_req, dcache_req;
    logic [12:0] icache_reqtag, dcache_reqtag;
    logic        icache_respcyc, dcache_respcyc, icache_reqack, dcache_reqack;
    logic [63:0] icache_resp, dcache_resp;
    logic [12:0] icache_resptag, dcache_resptag;
    logic        bus_reqcyc, bus_respack;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_respcyc, bus_reqack;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        arb_timeout;

    always #5 clk = ~clk;

    mem_bus_arbiter #(
        .BUS_DATA_WIDTH(64), .BUS_TAG_WIDTH(13), .INV_TAG(13'h800), .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk), .reset(reset),
        .icache_busreq(icache_busreq), .dcache_busreq(dcache_busreq),
        .icache_busidle(icache_busidle), .dcache_busidle(dcache_busidle),
        .icache_busgrant(icache_busgrant), .dcache_busgrant(dcache_busgrant),
        .icache_reqcyc(icache_reqcyc), .dcache_reqcyc(dcache_reqcyc),
        .icache_respack(icache_respack), .dcache_respack(dcache_respack),
        .icache_req(icache_req), .dcache_req(dcache_req),
        .icache_reqtag(icache_reqtag), .dcache_reqtag(dcache_reqtag),
        .icache_respcyc(icache_respcyc), .dcache_respcyc(dcache_respcyc),
        .icache_reqack(icache_reqack), .dcache_reqack(dcache_reqack),
        .icache_resp(icache_resp), .dcache_resp(dcache_resp),
        .icache_resptag(icache_resptag), .dcache_resptag(dcache_resptag),
        .bus_reqcyc(bus_reqcyc), .bus_respack(bus_respack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_reqack(bus_reqack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
`ifdef ARB_TIMEOUT_EN
        ,
        .arb_timeout(arb_timeout)
`endif
    );

`ifndef ARB_TIMEOUT_EN
    assign arb_timeout = 1'b0;
`endif

    typedef struct {
        int          cyc;
        string       name;
        logic [7:0]  ctl;
        logic        tmo;
        logic [63:0] req;
        logic [12:0] tag;
    } exp_t;

    exp_t q[$];
    exp_t e;
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    logic [7:0] w_ctl;
    assign w_ctl = {icache_busgrant, dcache_busgrant, bus_reqcyc, bus_respack,
                    icache_respcyc, dcache_respcyc, icache_reqack, dcache_reqack};

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ex(input string n, input logic [7:0] c, input logic [63:0] r,
                      input logic [12:0] t, input logic to);
        exp_t x;
        x.cyc = cyc; x.name = n; x.ctl = c; x.tmo = to; x.req = r; x.tag = t;
        q.push_back(x);
    endtask

    // Monitor: compares every expectation due in the current cycle
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            e = q.pop_front();
            checks++;
            if (e.cyc != cyc) begin
                errors++;
                $display("FAIL %s: expectation for cycle %0d was not checked in time (now %0d)",
                         e.name, e.cyc, cyc);
            end else if (w_ctl !== e.ctl || arb_timeout !== e.tmo ||
                         bus_req !== e.req || bus_reqtag !== e.tag) begin
                errors++;
                $display("FAIL %s: got ctl=%b tmo=%b req=%h tag=%h, want ctl=%b tmo=%b req=%h tag=%h",
                         e.name, w_ctl, arb_timeout, bus_req, bus_reqtag,
                         e.ctl, e.tmo, e.req, e.tag);
            end
        end
    end

    initial begin
        reset = 1'b1;
        {icache_busreq, dcache_busreq, icache_busidle, dcache_busidle} = '0;
        {icache_reqcyc, dcache_reqcyc, icache_respack, dcache_respack} = '0;
        icache_req = 64'h2000; icache_reqtag = 13'h007;
        dcache_req = 64'h0;    dcache_reqtag = 13'h0;
        bus_respcyc = 1'b0; bus_reqack = 1'b0;
        bus_resp = 64'hdead_beef; bus_resptag = 13'h0;

        // Reset state; invalidate still reaches D
        tick();
        bus_respcyc = 1'b1; bus_resptag = 13'h800;
        ex("rst_state_inv", 8'b0000_0100, 64'h0, 13'h0, 1'b0);

        // Lone D request, grant one cycle later
        tick();
        bus_respcyc = 1'b0; reset = 1'b0; dcache_busreq = 1'b1;
        ex("idle_dreq", 8'b0000_0000, 64'h0, 13'h0, 1'b0);
        tick();
        dcache_reqcyc = 1'b1; dcache_req = 64'h1000; dcache_reqtag = 13'h005;
        ex("d_grant_mux", 8'b0110_0000, 64'h1000, 13'h005, 1'b0);
        tick();
        dcache_reqcyc = 1'b0; dcache_busreq = 1'b0; bus_reqack = 1'b1; dcache_respack = 1'b1;
        ex("d_reqack", 8'b0101_0001, 64'h1000, 13'h005, 1'b0);
        tick();
        bus_reqack = 1'b0; dcache_respack = 1'b0; dcache_busidle = 1'b1;
        ex("d_hold", 8'b0100_0000, 64'h1000, 13'h005, 1'b0);
        tick();
        ex("d_turn", 8'b0000_0000, 64'h0, 13'h0, 1'b0);
        tick();
        bus_respcyc = 1'b1; bus_resptag = 13'h100;
        ex("idle_drop", 8'b0000_0000, 64'h0, 13'h0, 1'b0);
        reset = 1'b1;

        // Both request out of reset: I first, then D after turnaround
        tick();
        bus_respcyc = 1'b0; dcache_busidle = 1'b0; reset = 1'b0;
        icache_busreq = 1'b1; dcache_busreq = 1'b1;
        dcache_req = 64'h3000; dcache_reqtag = 13'h009;
        ex("rst2_idle", 8'b0000_0000, 64'h0, 13'h0, 1'b0);
        tick();
        icache_reqcyc = 1'b1; bus_respcyc = 1'b1; bus_resptag = 13'h800;
        ex("i_grant_inv", 8'b1010_0100, 64'h2000, 13'h007, 1'b0);
        tick();
        icache_reqcyc = 1'b0; bus_resptag = 13'h100; icache_busidle = 1'b1; icache_busreq = 1'b0;
        ex("i_resp", 8'b1000_1000, 64'h2000, 13'h007, 1'b0);
        tick();
        bus_respcyc = 1'b0; icache_busidle = 1'b0;
        ex("i_turn", 8'b0000_0000, 64'h0, 13'h0, 1'b0);
        tick();
        bus_reqack = 1'b1;
        ex("d_after_turn", 8'b0100_0001, 64'h3000, 13'h009, 1'b0);

        // Reset mid-ownership with a live request
        tick();
        bus_reqack = 1'b0; dcache_reqcyc = 1'b1; reset = 1'b1;
        ex("d_pre_reset", 8'b0110_0000, 64'h3000, 13'h009, 1'b0);
        tick();
        ex("reset_mid", 8'b0000_0000, 64'h0, 13'h0, 1'b0);
        reset = 1'b0; icache_busreq = 1'b1;
        tick();
        dcache_reqcyc = 1'b0;
        ex("post_reset_i", 8'b1000_0000, 64'h2000, 13'h007, 1'b0);

`ifdef ARB_TIMEOUT_EN
        // I owns but never issues; watchdog forces release after 8 cycles
        reset = 1'b1;
        tick();
        reset = 1'b0;
        ex("to_idle", 8'b0000_0000, 64'h0, 13'h0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            tick();
            ex("to_own_i", 8'b1000_0000, 64'h2000, 13'h007, 1'b0);
        end
        tick();
        ex("to_turn", 8'b0000_0000, 64'h0, 13'h0, 1'b1);
        tick();
        ex("to_grant_d", 8'b0100_0000, 64'h3000, 13'h009, 1'b1);
`endif

        icache_busreq = 1'b0; dcache_busreq = 1'b0;
        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, want 0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
